bcd_to_binary_seq: RTL and testbench

Multi-cycle BCD-to-binary converter using reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8).
Converts packed BCD time fields (user-set hours/minutes/seconds, year digits) back into the binary counter domain.
Sits between the time-set/entry logic and the binary timekeeping counters.
Valid/ready handshake on both sides; one conversion in flight at a time.

---
 rtl/clock_pkg.sv | 14 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bcd_to_binary_seq.sv | 115 +++++++++++
 tb/tb_bcd_to_binary_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types for the BCD <-> binary time-field converters.
package clock_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: a digit of 8 or more after a
// right shift had a 10 shifted into it, so it is pulled back by 3.
module bcd_digit_adjust
  import clock_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= 4'd8) ? bcd_digit_t'(digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit checking is enabled with `define BCD_TO_BIN_CHECK_EN.
module bcd_to_binary_seq
  import clock_pkg::*;
#(
  parameter  int NUM_DIGITS = 2,
  localparam int BIN_W      = $clog2(10 ** NUM_DIGITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int DW    = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  conv_state_t      state;
  logic [DW-1:0]    digit_reg;
  logic [BIN_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0]    shifted_digits;
  logic [DW-1:0]    adj_digits;
  logic [BIN_W-1:0] next_acc;

  assign in_ready       = (state == IDLE);
  assign shifted_digits = digit_reg >> 1;
  assign next_acc       = {digit_reg[0], acc_reg[BIN_W-1:1]};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit   (shifted_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted(adj_digits[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic invalid_in;
  logic invalid_q;
  logic err_q;

  always_comb begin
    invalid_in = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) invalid_in = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // The final SHIFT edge both shifts and publishes the result, giving a
  // fixed BIN_W-edge latency from the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      digit_reg <= '0;
      acc_reg   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
      invalid_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            digit_reg <= bcd_in;
            acc_reg   <= '0;
            cnt       <= '0;
            state     <= SHIFT;
`ifdef BCD_TO_BIN_CHECK_EN
            invalid_q <= invalid_in;
            err_q     <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          digit_reg <= adj_digits;
          acc_reg   <= next_acc;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef BCD_TO_BIN_CHECK_EN
            err_q     <= invalid_q;
            bin_out   <= invalid_q ? '0 : next_acc;
`else
            bin_out   <= next_acc;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases plus random BCD
// pairs compared against a decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;

  localparam int NUM_DIGITS = 2;
  localparam int BIN_W      = 7;
  localparam int LATENCY    = 7;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int checkCount = 0;
  int passCount  = 0;
  int lastBin    = 0;

  bcd_to_binary_seq #(.NUM_DIGITS(NUM_DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    else
      passCount++;
  endtask

  // Decimal value of the packed digits; nibbles above 9 mark the input invalid.
  function automatic int refValue(input logic [7:0] bcd, output bit invalid);
    int value = 0;
    int weight = 1;
    invalid = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      int d = int'(bcd[i*4 +: 4]);
      if (d > 9) invalid = 1;
      value += d * weight;
      weight *= 10;
    end
    return value;
  endfunction

  // mode 0: plain; 1: stray in_valid during SHIFT; 2: stray in_valid in DONE.
  task automatic applyStimulus(input logic [7:0] bcd, input int holdCycles,
                               input int mode, input logic [7:0] strayBcd);
    bit invalid;
    int expVal;
    int expErr;
    int edges;
    int waitCycles;
    expVal = refValue(bcd, invalid);
`ifdef BCD_TO_BIN_CHECK_EN
    expErr = invalid ? 1 : 0;
    if (invalid) expVal = 0;
`else
    expErr = 0;
`endif
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk); @(negedge clk); waitCycles++;
    end
    checkOutput("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    bcd_in   = bcd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 8'h00;
    checkOutput("in_ready_busy", in_ready, 0);
    edges = 0;
    while (edges < 20) begin
      if (mode == 1 && edges == 2) begin
        in_valid = 1'b1;
        bcd_in   = strayBcd;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      if (bin_out !== lastBin[BIN_W-1:0])
        checkOutput("bin_hold_during_shift", bin_out, lastBin);
    end
    checkOutput($sformatf("latency_%02h", bcd), edges, LATENCY);
    checkOutput($sformatf("bin_%02h", bcd), bin_out, expVal);
    checkOutput($sformatf("err_%02h", bcd), err, expErr);
    lastBin = expVal;
    for (int c = 0; c < holdCycles; c++) begin
      if (mode == 2) begin
        in_valid = 1'b1;
        bcd_in   = strayBcd;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_bin", bin_out, expVal);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("valid_cleared", out_valid, 0);
    checkOutput("in_ready_after", in_ready, 1);
    checkOutput("bin_hold_idle", bin_out, expVal);
    if (mode != 0) begin
      edges = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); @(negedge clk);
        if (out_valid) edges++;
      end
      checkOutput("no_stray_result", edges, 0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = 8'h00;
    #23;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_bin", bin_out, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h99, 0, 0, 8'h00);
    applyStimulus(8'h00, 0, 0, 8'h00);
    applyStimulus(8'h59, 0, 0, 8'h00);
    applyStimulus(8'h23, 5, 2, 8'h45);
    applyStimulus(8'h47, 0, 1, 8'h12);

    // Reset three SHIFT edges into a conversion.
    in_valid = 1'b1;
    bcd_in   = 8'h88;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_bin", bin_out, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    lastBin = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h31, 0, 0, 8'h00);

`ifdef BCD_TO_BIN_CHECK_EN
    applyStimulus(8'h3A, 0, 0, 8'h00);
    applyStimulus(8'h10, 0, 0, 8'h00);
`endif

    for (int n = 0; n < 20; n++) begin
      rb[7:4] = 4'($urandom_range(0, 9));
      rb[3:0] = 4'($urandom_range(0, 9));
      applyStimulus(rb, int'($urandom_range(0, 2)), 0, 8'h00);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
